// File: rtl/fan_pwm_gen_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fan_pwm_gen_if : speed request / PWM status bundle for fan_pwm_gen
// Rev 1.0
// ---------------------------------------------------------------------------
interface fan_pwm_gen_if;
  logic       tick_en;
  logic [1:0] speed_sel;
  logic       pwm_out;
  logic [6:0] duty_cur;
  logic       running;
  logic       ramping;

  modport master (
    output tick_en, speed_sel,
    input  pwm_out, duty_cur, running, ramping
  );

  modport slave (
    input  tick_en, speed_sel,
    output pwm_out, duty_cur, running, ramping
  );
endinterface
`default_nettype wire

// File: rtl/fan_pwm_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fan_pwm_gen : fan PWM generator with OFF/RUN control and optional soft-start
//               ramp (define FAN_SOFT_START_EN to build the RAMP state)
// Rev 1.0
// ---------------------------------------------------------------------------
module fan_pwm_gen #(
  parameter int PERIOD    = 100,
  parameter int RAMP_STEP = 5
) (
  input  logic             clk_in,
  input  logic             rst_n,
  fan_pwm_gen_if.slave     bus
);

`ifdef FAN_SOFT_START_EN
  typedef enum logic [1:0] {ST_OFF = 2'd0, ST_RUN = 2'd1, ST_RAMP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_OFF = 2'd0, ST_RUN = 2'd1} state_t;
`endif

  localparam logic [6:0]  LAST_PHASE = 7'(PERIOD - 1);
  localparam logic [13:0] PERIOD_W   = 14'(PERIOD);

  if (PERIOD < 2 || PERIOD > 127 || RAMP_STEP < 1 || RAMP_STEP > 100) begin : g_param_check
    $error("fan_pwm_gen: PERIOD or RAMP_STEP out of range");
  end

  state_t      state, state_next;
  logic [6:0]  phase;
  logic [6:0]  duty, duty_next;
  logic [6:0]  target;
  logic [13:0] thresh;
  logic        boundary;
  logic        pwm_q;

  assign boundary = bus.tick_en && (phase == LAST_PHASE);

  always_comb begin
    case (bus.speed_sel)
      2'b00:   target = 7'd0;
      2'b01:   target = 7'd30;
      2'b10:   target = 7'd60;
      default: target = 7'd100;
    endcase
  end

  // duty 100 gives thresh == PERIOD, so phase < thresh holds across the wrap
  assign thresh = (14'(duty) * PERIOD_W) / 14'd100;

`ifdef FAN_SOFT_START_EN
  localparam logic [7:0] STEP_W = 8'(RAMP_STEP);
  logic [7:0] ramp_sum;
  logic       ramp_hit;
  assign ramp_sum = {1'b0, duty} + STEP_W;
  assign ramp_hit = (ramp_sum >= {1'b0, target});
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_OFF;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    duty_next  = duty;
    if (boundary) begin
      if (target == 7'd0) begin
        state_next = ST_OFF;
        duty_next  = 7'd0;
      end else if (target <= duty) begin
        // decreases (and an exact match) settle immediately
        state_next = ST_RUN;
        duty_next  = target;
      end else begin
`ifdef FAN_SOFT_START_EN
        if (ramp_hit) begin
          state_next = ST_RUN;
          duty_next  = target;
        end else begin
          state_next = ST_RAMP;
          duty_next  = ramp_sum[6:0];
        end
`else
        state_next = ST_RUN;
        duty_next  = target;
`endif
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 7'd0;
      duty  <= 7'd0;
      pwm_q <= 1'b0;
    end else begin
      if (bus.tick_en) begin
        phase <= (phase == LAST_PHASE) ? 7'd0 : phase + 7'd1;
      end
      duty  <= duty_next;
      pwm_q <= ({7'd0, phase} < thresh);
    end
  end

  assign bus.pwm_out  = pwm_q;
  assign bus.duty_cur = duty;
  assign bus.running  = (state != ST_OFF);
`ifdef FAN_SOFT_START_EN
  assign bus.ramping  = (state == ST_RAMP);
`else
  assign bus.ramping  = 1'b0;
`endif

endmodule
`default_nettype wire
